// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data RAM: the core load/store port
// and an external master share DMEM one access at a time, with read data returned per owner.
module dmem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int CORE_PRIO  = 0,
  parameter int STARVE_MAX = 3
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          x_req,
  input  logic          x_we,
  input  logic [AW-1:0] x_addr,
  input  logic [DW-1:0] x_wdata,
  output logic          x_gnt,
  output logic          x_rvalid,
  output logic [DW-1:0] x_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        state_r;
  logic [2:0]    lat_cnt_r;
  logic          rr_last_r;     // 1: the external port took the most recent grant
  logic [3:0]    starve_cnt_r;
  logic          owner_r;       // 1: the transaction in flight belongs to the external port
  logic          c_gnt_r;
  logic          x_gnt_r;
  logic          c_rvalid_r;
  logic          x_rvalid_r;
  logic          m_en_r;
  logic          m_we_r;
  logic [AW-1:0] m_addr_r;
  logic [DW-1:0] m_wdata_r;
  logic [DW-1:0] rdata_r;

  logic          contested_s;
  logic          win_x_s;
  logic [3:0]    starve_nxt_s;

  // Winner selection and the starvation counter's next value for an IDLE-cycle arbitration
  always_comb begin
    contested_s  = c_req & x_req;
    win_x_s      = 1'b0;
    starve_nxt_s = starve_cnt_r;
    if (contested_s) begin
      if (CORE_PRIO != 0) begin
        win_x_s = (starve_cnt_r >= 4'(STARVE_MAX));
        if (win_x_s) begin
          starve_nxt_s = 4'd0;
        end else if (starve_cnt_r != 4'hF) begin
          starve_nxt_s = starve_cnt_r + 4'd1;
        end else begin
          starve_nxt_s = starve_cnt_r;
        end
      end else begin
        win_x_s      = ~rr_last_r;
        starve_nxt_s = starve_cnt_r;
      end
    end else if (x_req) begin
      win_x_s      = 1'b1;
      starve_nxt_s = 4'd0;
    end else begin
      win_x_s      = 1'b0;
      starve_nxt_s = starve_cnt_r;
    end
  end

  // Access sequencer: grant, one DMEM strobe, latency wait, response pulse
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r      <= IDLE;
      lat_cnt_r    <= 3'd0;
      rr_last_r    <= 1'b1;
      starve_cnt_r <= 4'd0;
      owner_r      <= 1'b0;
      c_gnt_r      <= 1'b0;
      x_gnt_r      <= 1'b0;
      c_rvalid_r   <= 1'b0;
      x_rvalid_r   <= 1'b0;
      m_en_r       <= 1'b0;
      m_we_r       <= 1'b0;
      m_addr_r     <= '0;
      m_wdata_r    <= '0;
      rdata_r      <= '0;
    end else begin
      c_gnt_r    <= 1'b0;
      x_gnt_r    <= 1'b0;
      c_rvalid_r <= 1'b0;
      x_rvalid_r <= 1'b0;
      m_en_r     <= 1'b0;
      case (state_r)
        IDLE: begin
          if (c_req || x_req) begin
            owner_r      <= win_x_s;
            c_gnt_r      <= ~win_x_s;
            x_gnt_r      <= win_x_s;
            m_en_r       <= 1'b1;
            m_we_r       <= win_x_s ? x_we    : c_we;
            m_addr_r     <= win_x_s ? x_addr  : c_addr;
            m_wdata_r    <= win_x_s ? x_wdata : c_wdata;
            rr_last_r    <= win_x_s;
            starve_cnt_r <= starve_nxt_s;
            state_r      <= ISSUE;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          if (m_we_r) begin
            state_r <= IDLE;
          end else begin
            lat_cnt_r <= 3'(MEM_LAT - 1);
            state_r   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt_r == 3'd0) begin
            rdata_r    <= m_rdata;
            c_rvalid_r <= ~owner_r;
            x_rvalid_r <= owner_r;
            state_r    <= RESP;
          end else begin
            lat_cnt_r <= lat_cnt_r - 3'd1;
          end
        end
        RESP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign c_gnt    = c_gnt_r;
  assign x_gnt    = x_gnt_r;
  assign c_rvalid = c_rvalid_r;
  assign x_rvalid = x_rvalid_r;
  assign c_rdata  = rdata_r;
  assign x_rdata  = rdata_r;
  assign m_en     = m_en_r;
  assign m_we     = m_we_r;
  assign m_addr   = m_addr_r;
  assign m_wdata  = m_wdata_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (round-robin/latency 1 and core-priority/latency 3)
// driven side by side, checked each cycle against a transaction-level model plus literal checks.
module tb_dmem_arbiter;

  localparam int NI   = 2;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;
  localparam int SMAX = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc    = 0;
  int total  = 0;
  int bad    = 0;
  bit cmp_en = 1'b0;
  bit hold   = 1'b0;
  bit rec    = 1'b0;

  logic [NI-1:0]        c_req, c_we, x_req, x_we;
  logic [NI-1:0][31:0]  c_addr, c_wdata, x_addr, x_wdata;
  logic [NI-1:0]        c_gnt, c_rvalid, x_gnt, x_rvalid, m_en, m_we;
  logic [NI-1:0][31:0]  c_rdata, x_rdata, m_addr, m_wdata, m_rdata;

  dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT0), .CORE_PRIO(0), .STARVE_MAX(SMAX)) u0 (
    .CLK(clk), .RESET_N(rst_n),
    .c_req(c_req[0]), .c_we(c_we[0]), .c_addr(c_addr[0]), .c_wdata(c_wdata[0]),
    .c_gnt(c_gnt[0]), .c_rvalid(c_rvalid[0]), .c_rdata(c_rdata[0]),
    .x_req(x_req[0]), .x_we(x_we[0]), .x_addr(x_addr[0]), .x_wdata(x_wdata[0]),
    .x_gnt(x_gnt[0]), .x_rvalid(x_rvalid[0]), .x_rdata(x_rdata[0]),
    .m_en(m_en[0]), .m_we(m_we[0]), .m_addr(m_addr[0]), .m_wdata(m_wdata[0]),
    .m_rdata(m_rdata[0])
  );

  dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT1), .CORE_PRIO(1), .STARVE_MAX(SMAX)) u1 (
    .CLK(clk), .RESET_N(rst_n),
    .c_req(c_req[1]), .c_we(c_we[1]), .c_addr(c_addr[1]), .c_wdata(c_wdata[1]),
    .c_gnt(c_gnt[1]), .c_rvalid(c_rvalid[1]), .c_rdata(c_rdata[1]),
    .x_req(x_req[1]), .x_we(x_we[1]), .x_addr(x_addr[1]), .x_wdata(x_wdata[1]),
    .x_gnt(x_gnt[1]), .x_rvalid(x_rvalid[1]), .x_rdata(x_rdata[1]),
    .m_en(m_en[1]), .m_we(m_we[1]), .m_addr(m_addr[1]), .m_wdata(m_wdata[1]),
    .m_rdata(m_rdata[1])
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  function automatic logic [31:0] init_word(input int i);
    return (i == 8) ? 32'h1234_5678 : (32'hA500_0000 | 32'(i));
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // DMEM stand-in: read data is only valid in the single cycle MEM_LAT after the strobe
  logic [31:0] dmem [NI][64];
  int          pend_at [NI] = '{-1, -1};
  logic [31:0] pend_d  [NI];

  initial begin
    for (int k = 0; k < NI; k++)
      for (int i = 0; i < 64; i++)
        dmem[k][i] <= init_word(i);
  end

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (rst_n && m_en[k]) begin
        if (m_we[k]) begin
          dmem[k][m_addr[k][7:2]] <= m_wdata[k];
        end else begin
          pend_at[k] <= cyc + lat_of(k);
          pend_d[k]  <= dmem[k][m_addr[k][7:2]];
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NI; k++)
      m_rdata[k] = (cyc == pend_at[k]) ? pend_d[k] : (32'hBAD0_0000 ^ 32'(cyc));
  end

  // Reference model: each grant decided from the rules and its visible effects scheduled by cycle
  logic [31:0] mmem [NI][64];
  int          free_at [NI];
  int          gnt_at  [NI];
  int          resp_at [NI];
  int          starve  [NI];
  bit          gnt_who [NI];
  bit          tie_x   [NI];
  bit          e_we    [NI];
  logic [31:0] e_addr  [NI];
  logic [31:0] e_wdata [NI];
  logic [31:0] rd_old  [NI];
  logic [31:0] rd_new  [NI];

  initial begin
    for (int k = 0; k < NI; k++)
      for (int i = 0; i < 64; i++)
        mmem[k][i] <= init_word(i);
  end

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        free_at[k] <= 0;
        gnt_at[k]  <= -1;
        resp_at[k] <= -1;
        starve[k]  <= 0;
        gnt_who[k] <= 1'b0;
        tie_x[k]   <= 1'b0;
        e_we[k]    <= 1'b0;
        e_addr[k]  <= 32'h0;
        e_wdata[k] <= 32'h0;
        rd_old[k]  <= 32'h0;
        rd_new[k]  <= 32'h0;
      end else if (cyc >= free_at[k] && (c_req[k] || x_req[k])) begin
        automatic bit          both;
        automatic bit          w;
        automatic bit          we;
        automatic logic [31:0] a;
        automatic logic [31:0] d;
        both = c_req[k] && x_req[k];
        if (both) w = (k == 0) ? tie_x[k] : (starve[k] >= SMAX);
        else      w = x_req[k];
        we = w ? x_we[k]    : c_we[k];
        a  = w ? x_addr[k]  : c_addr[k];
        d  = w ? x_wdata[k] : c_wdata[k];
        if (k == 1) begin
          if (w)         starve[k] <= 0;
          else if (both) starve[k] <= (starve[k] < 15) ? starve[k] + 1 : 15;
        end
        tie_x[k]   <= !w;
        gnt_at[k]  <= cyc + 1;
        gnt_who[k] <= w;
        e_we[k]    <= we;
        e_addr[k]  <= a;
        e_wdata[k] <= d;
        if (we) begin
          mmem[k][a[7:2]] <= d;
          free_at[k]      <= cyc + 2;
        end else begin
          rd_old[k]  <= rd_new[k];
          rd_new[k]  <= mmem[k][a[7:2]];
          resp_at[k] <= cyc + 2 + lat_of(k);
          free_at[k] <= cyc + 3 + lat_of(k);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %08h want %08h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < NI; k++) begin
        chk($sformatf("u%0d.c_gnt", k),    32'(c_gnt[k]),    32'(cyc == gnt_at[k] && !gnt_who[k]));
        chk($sformatf("u%0d.x_gnt", k),    32'(x_gnt[k]),    32'(cyc == gnt_at[k] &&  gnt_who[k]));
        chk($sformatf("u%0d.m_en", k),     32'(m_en[k]),     32'(cyc == gnt_at[k]));
        chk($sformatf("u%0d.m_we", k),     32'(m_we[k]),     32'(e_we[k]));
        chk($sformatf("u%0d.m_addr", k),   m_addr[k],        e_addr[k]);
        chk($sformatf("u%0d.m_wdata", k),  m_wdata[k],       e_wdata[k]);
        chk($sformatf("u%0d.c_rvalid", k), 32'(c_rvalid[k]), 32'(cyc == resp_at[k] && !gnt_who[k]));
        chk($sformatf("u%0d.x_rvalid", k), 32'(x_rvalid[k]), 32'(cyc == resp_at[k] &&  gnt_who[k]));
        chk($sformatf("u%0d.c_rdata", k),  c_rdata[k],       (cyc >= resp_at[k]) ? rd_new[k] : rd_old[k]);
        chk($sformatf("u%0d.x_rdata", k),  x_rdata[k],       (cyc >= resp_at[k]) ? rd_new[k] : rd_old[k]);
      end
    end
  end

  int gw0[$], gw1[$], gc0[$];

  // Advance one cycle; requesters drop req after their grant unless holding
  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      if (rec && (c_gnt[k] || x_gnt[k])) begin
        if (k == 0) begin
          gw0.push_back(x_gnt[k] ? 1 : 0);
          gc0.push_back(cyc);
        end else begin
          gw1.push_back(x_gnt[k] ? 1 : 0);
        end
      end
      if (!hold && c_gnt[k]) c_req[k] = 1'b0;
      if (!hold && x_gnt[k]) x_req[k] = 1'b0;
    end
  endtask

  task automatic core_cmd(input int k, input logic we, input logic [31:0] a, input logic [31:0] d);
    c_req[k] = 1'b1; c_we[k] = we; c_addr[k] = a; c_wdata[k] = d;
  endtask

  task automatic ext_cmd(input int k, input logic we, input logic [31:0] a, input logic [31:0] d);
    x_req[k] = 1'b1; x_we[k] = we; x_addr[k] = a; x_wdata[k] = d;
  endtask

  int exp0 [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
  int exp1 [8] = '{0, 0, 0, 1, 0, 0, 0, 1};

  initial begin
    c_req = '0; c_we = '0; c_addr = '0; c_wdata = '0;
    x_req = '0; x_we = '0; x_addr = '0; x_wdata = '0;

    @(posedge clk); #1;
    cmp_en = 1'b1;
    @(posedge clk); #1;
    chk("reset.c_gnt",   32'(c_gnt[0]), 32'h0);
    chk("reset.m_en",    32'(m_en[1]),  32'h0);
    chk("reset.c_rdata", c_rdata[0],    32'h0);
    rst_n = 1'b1;
    tick();

    // Core write: grant and strobe one cycle after the request
    for (int k = 0; k < NI; k++) core_cmd(k, 1'b1, 32'h10, 32'hDEAD_BEEF);
    tick();
    chk("wr.c_gnt",   32'(c_gnt[0]), 32'h1);
    chk("wr.x_gnt",   32'(x_gnt[0]), 32'h0);
    chk("wr.m_en",    32'(m_en[0]),  32'h1);
    chk("wr.m_we",    32'(m_we[0]),  32'h1);
    chk("wr.m_addr",  m_addr[0],     32'h10);
    chk("wr.m_wdata", m_wdata[0],    32'hDEAD_BEEF);
    tick();
    chk("wr.m_en_off", 32'(m_en[0]),     32'h0);
    chk("wr.no_rv",    32'(c_rvalid[0]), 32'h0);

    // Core read 0x20; external write arrives while the latency-3 instance waits
    for (int k = 0; k < NI; k++) core_cmd(k, 1'b0, 32'h20, 32'h0);
    tick();
    chk("rd.u1_gnt", 32'(c_gnt[1]), 32'h1);
    tick();
    ext_cmd(1, 1'b1, 32'h30, 32'hCAFE_0001);
    tick();
    chk("rd.u0_rvalid",  32'(c_rvalid[0]), 32'h1);
    chk("rd.u0_rdata",   c_rdata[0],       32'h1234_5678);
    chk("rd.u0_xrvalid", 32'(x_rvalid[0]), 32'h0);
    chk("rd.u1_xgnt_a",  32'(x_gnt[1]),    32'h0);
    tick();
    tick();
    chk("rd.u1_rvalid", 32'(c_rvalid[1]), 32'h1);
    chk("rd.u1_rdata",  c_rdata[1],       32'h1234_5678);
    chk("rd.u1_xgnt_b", 32'(x_gnt[1]),    32'h0);
    tick();
    chk("rd.u1_xgnt_c", 32'(x_gnt[1]), 32'h0);
    tick();
    chk("rd.u1_xgnt_d", 32'(x_gnt[1]), 32'h1);
    tick();
    tick();

    // Reset while both instances wait on a read
    for (int k = 0; k < NI; k++) core_cmd(k, 1'b0, 32'h20, 32'h0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst.u%0d.gnt", k),    32'({c_gnt[k], x_gnt[k], m_en[k], m_we[k]}), 32'h0);
      chk($sformatf("rst.u%0d.rdata", k),  c_rdata[k], 32'h0);
      chk($sformatf("rst.u%0d.m_addr", k), m_addr[k],  32'h0);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      for (int k = 0; k < NI; k++)
        chk($sformatf("rst.u%0d.no_rv%0d", k, i), 32'({c_rvalid[k], x_rvalid[k]}), 32'h0);
    end

    // Both ports hold write requests: round-robin vs core priority with starvation guard
    hold = 1'b1;
    rec  = 1'b1;
    for (int k = 0; k < NI; k++) begin
      core_cmd(k, 1'b1, 32'h40, 32'h1111_0000);
      ext_cmd(k, 1'b1, 32'h80, 32'h2222_0000);
    end
    repeat (17) tick();
    c_req = '0;
    x_req = '0;
    hold  = 1'b0;
    rec   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rr.order%0d", i),   32'((gw0.size() > i) ? gw0[i] : 99), 32'(exp0[i]));
      chk($sformatf("prio.order%0d", i), 32'((gw1.size() > i) ? gw1[i] : 99), 32'(exp1[i]));
    end
    for (int i = 1; i < 8; i++)
      chk($sformatf("rr.gap%0d", i), 32'((gc0.size() > i) ? gc0[i] - gc0[i-1] : 99), 32'd2);
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
